scratchpad_bank_ctrl: RTL and testbench
=======================================

// Module: scratchpad_bank_ctrl
// PURPOSE
//  Multi-bank matrix scratchpad: SPN banks of ELEM_NUM BW-bit elements each.
//  Adds to the single-cycle bus scratchpad: registered bus reads, a sequential bank-clear engine,
//  and a valid/ready streaming drain of one bank, element by element.
//  Sits between the APB-style register bus and the matmul datapath.
//  The datapath reads one whole bank via mat_o; the stream port feeds the result/DMA path.
// PARAMETERS
//  DW        8            matrix element width (sets MAX_DIM)
//  BW        32           bus/storage word width
//  MAX_DIM   BW/DW        matrix side length
//  ELEM_NUM  MAX_DIM**2   elements per bank
//  SPN       4            number of banks, 1..8
//  ADDR_W    4            element index width; 2**ADDR_W >= ELEM_NUM
//  BANK_W    3            bank select width
// PORTS
//  clk_i        in   1             clock, rising edge
//  reset_i      in   1             async active-high reset
//  bus_wr_en_i  in   1             bus write strobe
//  bus_rd_en_i  in   1             bus read strobe
//  bus_bank_i   in   BANK_W        bus bank select
//  bus_addr_i   in   ADDR_W        bus element index
//  bus_data_i   in   BW            bus write data
//  bus_data_o   out  BW            bus read data, registered
//  bus_rvalid_o out  1             1-cycle pulse, bus_data_o updated
//  bus_err_o    out  1             1-cycle pulse: access dropped/out of range
//  mat_sel_i    in   BANK_W        bank driven on mat_o
//  mat_o        out  BW*ELEM_NUM   element j at [(j+1)*BW-1 -: BW]
//  clr_start_i  in   1             start clear of clr_bank_i
//  clr_bank_i   in   BANK_W        bank to clear
//  str_start_i  in   1             start stream of str_bank_i
//  str_bank_i   in   BANK_W        bank to stream
//  str_valid_o  out  1             stream data valid
//  str_ready_i  in   1             stream consumer ready
//  str_data_o   out  BW            stream element
//  str_last_o   out  1             current element is index ELEM_NUM-1
//  busy_o       out  1             FSM not IDLE
// BEHAVIOUR
//  Reset (async, any time, incl. mid-clear/stream):
//   all mem = 0; FSM=IDLE; every output = 0; any in-flight operation is aborted.
//  FSM states: IDLE, CLEAR, STREAM; busy_o = (state != IDLE).
//   IDLE->CLEAR on clr_start_i with clr_bank_i<SPN; else IDLE->STREAM on str_start_i with str_bank_i<SPN.
//   clr_start_i has priority when both starts are high. Starts are ignored when busy or bank>=SPN.
//   Bank and idx (=0) are latched on the start edge.
//  CLEAR: writes mem[bank][idx]=0, idx++ each cycle, for ELEM_NUM cycles.
//   After idx==ELEM_NUM-1 the FSM goes to IDLE (busy high exactly ELEM_NUM cycles).
//  STREAM: str_valid_o=1; str_data_o=mem[bank][idx]; str_last_o=(idx==ELEM_NUM-1).
//   Transfer = valid&ready -> idx++. Data/last are held stable while valid&!ready.
//   After the last transfer: IDLE next cycle, valid=0. Valid never drops before last is taken.
//  Bus write: mem[bus_bank_i][bus_addr_i] <= bus_data_i.
//   Dropped with bus_err_o pulse (next cycle) if bank>=SPN, addr>=ELEM_NUM,
//   or bank == the bank being cleared/streamed. Writes to other banks proceed during busy.
//  Bus read: latency 1; bus_data_o <= mem[bank][addr], bus_rvalid_o pulses.
//   Out-of-range read -> data 0, rvalid=1, err=1. bus_data_o holds between reads.
//  Same-cycle read+write to the same element: read returns old data. Reads are never blocked by busy.
//  mat_o: combinational from mat_sel_i; all zeros if mat_sel_i>=SPN. Reflects writes the cycle after.
// TESTING (DW=8,BW=32,SPN=4,ELEM_NUM=16)
//  Write bank2 addr5=0xDEADBEEF, read it -> bus_data_o=0xDEADBEEF 1 cycle later;
//   mat_sel_i=2 -> mat_o[191:160]=0xDEADBEEF.
//  Fill bank1 with 0..15, clr_start bank1 -> busy 16 cycles, then all 16 read 0;
//   a bus write to bank1 during clear -> bus_err_o, no effect.
//  Fill bank0 with i*3, stream with ready toggling 1,0 -> 16 transfers 0,3..45.
//   Data stable while stalled; str_last_o only on 45; busy drops next cycle.
//  clr_start and str_start same cycle -> CLEAR taken; str_start during busy is ignored.
//  Write bank 5 / addr 20 -> bus_err_o, no mem change; read bank 7 -> 0 with err.
//  Assert reset_i mid-stream (idx=7) -> str_valid_o, busy_o and mem all 0 asynchronously.

Source files
------------

// File: rtl/scratchpad_bank_ctrl.sv
// Multi-bank matrix scratchpad with registered bus reads, a sequential bank-clear engine and a valid/ready bank drain.
// Latency: bus read data/rvalid/err one cycle after the strobe; mat_o combinational; clear takes ELEM_NUM cycles.
// Backpressure: the stream holds data/last while valid&!ready; bus writes to the bank that is busy are dropped with an error pulse.
module scratchpad_bank_ctrl #(
  parameter int DW       = 8,
  parameter int BW       = 32,
  parameter int MAX_DIM  = BW / DW,
  parameter int ELEM_NUM = MAX_DIM * MAX_DIM,
  parameter int SPN      = 4,
  parameter int ADDR_W   = 4,
  parameter int BANK_W   = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   bus_wr_en_i,
  input  logic                   bus_rd_en_i,
  input  logic [BANK_W-1:0]      bus_bank_i,
  input  logic [ADDR_W-1:0]      bus_addr_i,
  input  logic [BW-1:0]          bus_data_i,
  output logic [BW-1:0]          bus_data_o,
  output logic                   bus_rvalid_o,
  output logic                   bus_err_o,
  input  logic [BANK_W-1:0]      mat_sel_i,
  output logic [BW*ELEM_NUM-1:0] mat_o,
  input  logic                   clr_start_i,
  input  logic [BANK_W-1:0]      clr_bank_i,
  input  logic                   str_start_i,
  input  logic [BANK_W-1:0]      str_bank_i,
  output logic                   str_valid_o,
  input  logic                   str_ready_i,
  output logic [BW-1:0]          str_data_o,
  output logic                   str_last_o,
  output logic                   busy_o
);

  // Internal index widths: just wide enough to address the banks/elements that exist.
  localparam int SB_W = (SPN > 1) ? $clog2(SPN) : 1;
  localparam int EA_W = (ELEM_NUM > 1) ? $clog2(ELEM_NUM) : 1;
  localparam int BK1  = BANK_W + 1;
  localparam int AD1  = ADDR_W + 1;
  // Limits held one bit wider than the port so SPN == 2**BANK_W still compares correctly.
  localparam logic [BANK_W:0] SPN_L    = BK1'(SPN);
  localparam logic [ADDR_W:0] ELEM_L   = AD1'(ELEM_NUM);
  localparam logic [EA_W-1:0] LAST_IDX = EA_W'(ELEM_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t          state_q;
  logic [SB_W-1:0] bank_q;
  logic [EA_W-1:0] idx_q;

  logic [BW-1:0] mem [SPN][ELEM_NUM];

  logic bus_bank_ok;
  logic bus_addr_ok;
  logic bus_conflict;
  logic wr_ok;
  logic wr_bad;
  logic rd_ok;
  logic rd_bad;
  logic clr_go;
  logic str_go;
  logic mat_sel_ok;

  logic [SB_W-1:0] bus_bank_idx;
  logic [EA_W-1:0] bus_elem_idx;
  logic [SB_W-1:0] mat_bank_idx;

  assign bus_bank_idx = bus_bank_i[SB_W-1:0];
  assign bus_elem_idx = bus_addr_i[EA_W-1:0];
  assign mat_bank_idx = mat_sel_i[SB_W-1:0];

  assign bus_bank_ok  = {1'b0, bus_bank_i} < SPN_L;
  assign bus_addr_ok  = {1'b0, bus_addr_i} < ELEM_L;
  // The bank owned by an active clear/stream is off limits to bus writes.
  assign bus_conflict = (state_q != S_IDLE) && bus_bank_ok && (bus_bank_idx == bank_q);

  assign wr_ok  = bus_wr_en_i && bus_bank_ok && bus_addr_ok && !bus_conflict;
  assign wr_bad = bus_wr_en_i && !wr_ok;
  assign rd_ok  = bus_rd_en_i && bus_bank_ok && bus_addr_ok;
  assign rd_bad = bus_rd_en_i && !rd_ok;

  assign clr_go     = clr_start_i && ({1'b0, clr_bank_i} < SPN_L);
  assign str_go     = str_start_i && ({1'b0, str_bank_i} < SPN_L);
  assign mat_sel_ok = {1'b0, mat_sel_i} < SPN_L;

  // Control FSM: latches bank/index on a start, walks the index for clear or stream, registers busy/valid/last.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      bank_q      <= '0;
      idx_q       <= '0;
      busy_o      <= 1'b0;
      str_valid_o <= 1'b0;
      str_last_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_go) begin
            state_q <= S_CLEAR;
            bank_q  <= clr_bank_i[SB_W-1:0];
            idx_q   <= '0;
            busy_o  <= 1'b1;
          end else if (str_go) begin
            state_q     <= S_STREAM;
            bank_q      <= str_bank_i[SB_W-1:0];
            idx_q       <= '0;
            busy_o      <= 1'b1;
            str_valid_o <= 1'b1;
            str_last_o  <= (LAST_IDX == '0);
          end
        end
        S_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_o  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (str_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= S_IDLE;
              idx_q       <= '0;
              busy_o      <= 1'b0;
              str_valid_o <= 1'b0;
              str_last_o  <= 1'b0;
            end else begin
              idx_q      <= idx_q + 1'b1;
              str_last_o <= ((idx_q + 1'b1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          idx_q       <= '0;
          busy_o      <= 1'b0;
          str_valid_o <= 1'b0;
          str_last_o  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: accepted bus writes plus the clear engine zeroing one element per cycle (never the same bank).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < SPN; b++) begin
        for (int e = 0; e < ELEM_NUM; e++) begin
          mem[b][e] <= '0;
        end
      end
    end else begin
      if (wr_ok) begin
        mem[bus_bank_idx][bus_elem_idx] <= bus_data_i;
      end
      if (state_q == S_CLEAR) begin
        mem[bank_q][idx_q] <= '0;
      end
    end
  end

  // Bus response: registered read data (old value on a same-cycle write), rvalid and error pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus_data_o   <= '0;
      bus_rvalid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      bus_rvalid_o <= bus_rd_en_i;
      bus_err_o    <= wr_bad || rd_bad;
      if (bus_rd_en_i) begin
        bus_data_o <= rd_ok ? mem[bus_bank_idx][bus_elem_idx] : '0;
      end
    end
  end

  // Whole-bank view for the datapath; an unpopulated bank select reads as zero.
  always_comb begin
    mat_o = '0;
    if (mat_sel_ok) begin
      for (int j = 0; j < ELEM_NUM; j++) begin
        mat_o[j*BW +: BW] = mem[mat_bank_idx][j];
      end
    end
  end

  // Stream data follows the registered index; the streamed bank cannot change underneath it.
  assign str_data_o = str_valid_o ? mem[bank_q][idx_q] : '0;

endmodule

// File: tb/tb_scratchpad_bank_ctrl.sv
module tb_scratchpad_bank_ctrl;

  localparam int BW  = 32;
  localparam int EN  = 16;
  localparam int AW  = 5;
  localparam int BKW = 3;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b0;
  logic             bus_wr_en_i = 1'b0;
  logic             bus_rd_en_i = 1'b0;
  logic [BKW-1:0]   bus_bank_i = '0;
  logic [AW-1:0]    bus_addr_i = '0;
  logic [BW-1:0]    bus_data_i = '0;
  logic [BW-1:0]    bus_data_o;
  logic             bus_rvalid_o;
  logic             bus_err_o;
  logic [BKW-1:0]   mat_sel_i = '0;
  logic [BW*EN-1:0] mat_o;
  logic             clr_start_i = 1'b0;
  logic [BKW-1:0]   clr_bank_i = '0;
  logic             str_start_i = 1'b0;
  logic [BKW-1:0]   str_bank_i = '0;
  logic             str_valid_o;
  logic             str_ready_i = 1'b0;
  logic [BW-1:0]    str_data_o;
  logic             str_last_o;
  logic             busy_o;

  scratchpad_bank_ctrl #(
    .DW(8), .BW(BW), .SPN(4), .ADDR_W(AW), .BANK_W(BKW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .bus_wr_en_i(bus_wr_en_i), .bus_rd_en_i(bus_rd_en_i),
    .bus_bank_i(bus_bank_i), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
    .bus_data_o(bus_data_o), .bus_rvalid_o(bus_rvalid_o), .bus_err_o(bus_err_o),
    .mat_sel_i(mat_sel_i), .mat_o(mat_o),
    .clr_start_i(clr_start_i), .clr_bank_i(clr_bank_i),
    .str_start_i(str_start_i), .str_bank_i(str_bank_i),
    .str_valid_o(str_valid_o), .str_ready_i(str_ready_i),
    .str_data_o(str_data_o), .str_last_o(str_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  typedef struct { logic [31:0] d; logic e; } rd_t;
  typedef struct { logic [31:0] d; logic l; } st_t;
  rd_t rd_q[$];
  st_t st_q[$];
  bit  werr_q[$];

  int          busy_cnt = 0;
  logic [31:0] stall_d;
  logic        stall_l;
  bit          stall_pend = 0;
  bit          idle_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_op(input bit wr, input bit rd, input logic [BKW-1:0] bank,
                        input logic [AW-1:0] addr, input logic [31:0] data);
    bus_wr_en_i = wr;
    bus_rd_en_i = rd;
    bus_bank_i  = bank;
    bus_addr_i  = addr;
    bus_data_i  = data;
    tick();
    bus_wr_en_i = 1'b0;
    bus_rd_en_i = 1'b0;
  endtask

  task automatic exp_rd(input logic [31:0] d, input logic e);
    rd_t r;
    r.d = d;
    r.e = e;
    rd_q.push_back(r);
  endtask

  task automatic exp_st(input logic [31:0] d, input logic l);
    st_t s;
    s.d = d;
    s.l = l;
    st_q.push_back(s);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    if (busy_o) chk("busy_timeout", 1, 0);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a bus response or a stream transfer.
  always @(negedge clk_i) begin
    rd_t r;
    st_t s;
    if (busy_o) busy_cnt++;
    if (bus_rvalid_o) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_data", bus_data_o, r.d);
        chk("rd_err", bus_err_o, r.e);
      end
    end else if (bus_err_o) begin
      if (werr_q.size() == 0) chk("err_unexpected", 1, 0);
      else void'(werr_q.pop_front());
    end
    if (idle_pend) begin
      chk("after_last_busy", busy_o, 0);
      chk("after_last_valid", str_valid_o, 0);
      idle_pend = 0;
    end
    if (stall_pend) begin
      chk("stall_valid", str_valid_o, 1);
      chk("stall_data", str_data_o, stall_d);
      chk("stall_last", str_last_o, stall_l);
      stall_pend = 0;
    end
    if (str_valid_o && str_ready_i) begin
      if (st_q.size() == 0) chk("str_unexpected", 1, 0);
      else begin
        s = st_q.pop_front();
        chk("str_data", str_data_o, s.d);
        chk("str_last", str_last_o, s.l);
        if (s.l) idle_pend = 1;
      end
    end else if (str_valid_o) begin
      stall_d    = str_data_o;
      stall_l    = str_last_o;
      stall_pend = 1;
    end
  end

  initial begin
    #1 reset_i = 1'b1;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", str_valid_o, 0);
    chk("rst_last", str_last_o, 0);
    chk("rst_rvalid", bus_rvalid_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_rdata", bus_data_o, 0);
    chk("rst_mat", |mat_o, 0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    tick();

    // Write/read and whole-bank view
    bus_op(1, 0, 3'd2, 5'd5, 32'hDEADBEEF);
    exp_rd(32'hDEADBEEF, 0);
    bus_op(0, 1, 3'd2, 5'd5, '0);
    mat_sel_i = 3'd2;
    #1;
    chk("mat_elem5", mat_o[191:160], 32'hDEADBEEF);
    chk("mat_others", |mat_o[159:0], 0);
    mat_sel_i = 3'd5;
    #1;
    chk("mat_bad_sel", |mat_o, 0);
    mat_sel_i = 3'd2;

    // Same-cycle read and write of one element returns the old value
    exp_rd(32'hDEADBEEF, 0);
    bus_op(1, 1, 3'd2, 5'd5, 32'h11111111);
    exp_rd(32'h11111111, 0);
    bus_op(0, 1, 3'd2, 5'd5, '0);
    #1;
    chk("mat_after_rw", mat_o[191:160], 32'h11111111);

    // Clear of bank1, racing a stream start; writes during the clear
    for (int i = 0; i < EN; i++) bus_op(1, 0, 3'd1, AW'(i), 32'(i));
    exp_rd(32'd9, 0);
    bus_op(0, 1, 3'd1, 5'd9, '0);
    str_ready_i = 1'b1;
    busy_cnt    = 0;
    clr_start_i = 1'b1;
    clr_bank_i  = 3'd1;
    str_start_i = 1'b1;
    str_bank_i  = 3'd0;
    tick();
    clr_start_i = 1'b0;
    str_start_i = 1'b0;
    werr_q.push_back(1'b1);
    bus_op(1, 0, 3'd1, 5'd3, 32'h0000AAAA);
    bus_op(1, 0, 3'd3, 5'd0, 32'h00000033);
    str_start_i = 1'b1;
    str_bank_i  = 3'd0;
    tick();
    str_start_i = 1'b0;
    chk("clr_no_stream", str_valid_o, 0);
    chk("clr_busy", busy_o, 1);
    wait_idle();
    chk("clr_busy_cycles", busy_cnt, 16);
    str_ready_i = 1'b0;
    tick();
    chk("idle_no_stream", str_valid_o, 0);
    for (int i = 0; i < EN; i++) begin
      exp_rd(32'd0, 0);
      bus_op(0, 1, 3'd1, AW'(i), '0);
    end
    exp_rd(32'h33, 0);
    bus_op(0, 1, 3'd3, 5'd0, '0);

    // Stream bank0 with ready toggling 1,0
    for (int i = 0; i < EN; i++) bus_op(1, 0, 3'd0, AW'(i), 32'(i * 3));
    for (int i = 0; i < EN; i++) exp_st(32'(i * 3), (i == EN - 1));
    str_start_i = 1'b1;
    str_bank_i  = 3'd0;
    tick();
    str_start_i = 1'b0;
    for (int k = 0; k < 80 && busy_o; k++) begin
      str_ready_i = (k % 2 == 0);
      tick();
    end
    if (busy_o) chk("stream_timeout", 1, 0);
    str_ready_i = 1'b0;
    repeat (2) tick();

    // Out-of-range accesses
    werr_q.push_back(1'b1);
    bus_op(1, 0, 3'd5, 5'd3, 32'hDEAD0000);
    werr_q.push_back(1'b1);
    bus_op(1, 0, 3'd0, 5'd20, 32'hDEAD0001);
    exp_rd(32'd12, 0);
    bus_op(0, 1, 3'd0, 5'd4, '0);
    exp_rd(32'd0, 1);
    bus_op(0, 1, 3'd7, 5'd0, '0);
    exp_rd(32'd0, 1);
    bus_op(0, 1, 3'd0, 5'd20, '0);
    exp_rd(32'd45, 0);
    bus_op(0, 1, 3'd0, 5'd15, '0);
    repeat (3) tick();
    chk("rd_hold", bus_data_o, 32'd45);

    // Reset in the middle of a stream, with element 7 on the port
    for (int i = 0; i < 7; i++) exp_st(32'(i * 3), 0);
    str_start_i = 1'b1;
    str_bank_i  = 3'd0;
    tick();
    str_start_i = 1'b0;
    str_ready_i = 1'b1;
    repeat (7) tick();
    str_ready_i = 1'b0;
    #1;
    chk("mid_valid", str_valid_o, 1);
    chk("mid_data", str_data_o, 32'd21);
    reset_i = 1'b1;
    #1;
    chk("arst_valid", str_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_data", str_data_o, 0);
    chk("arst_mat2", |mat_o, 0);
    mat_sel_i = 3'd0;
    #1;
    chk("arst_mat0", |mat_o, 0);
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
    exp_rd(32'd0, 0);
    bus_op(0, 1, 3'd2, 5'd5, '0);
    exp_rd(32'd0, 0);
    bus_op(0, 1, 3'd0, 5'd15, '0);
    repeat (3) tick();

    chk("rd_q_drained", rd_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    chk("werr_q_drained", werr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
